// File: rtl/cpu_pkg.sv
// Shared fetch-side definitions: instruction width, reset/NOP encodings,
// fetch FSM states and a word-alignment helper.
package cpu_pkg;

  localparam int          INS_W        = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP          = 32'h0000_0000;

  // RUN: normal fetching. DRAIN: waiting out a stale response after a redirect.
  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  // Fetch addresses are always word aligned; low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO of {pc_4, ins}. Flush wins over push and pop.
// The caller guarantees no push into a full buffer (unless popping)
// and no pop from an empty buffer.
module fetch_skid_buf
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 push,
  input  logic                 pop,
  input  logic [2*INS_W-1:0]   din,
  output logic [2*INS_W-1:0]   head,
  output logic [1:0]           count
);

  logic [2*INS_W-1:0] mem_q [2];
  logic               wr_ptr_q;
  logic               rd_ptr_q;
  logic [1:0]         cnt_q;

  // Storage, pointers and occupancy; flush empties the buffer outright.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= {32'h0, NOP};
      mem_q[1] <= {32'h0, NOP};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs a single-outstanding req/ack
// fetch to instruction memory and presents {pc+4, ins, valid} to IF/ID
// through a 2-entry skid buffer.
//
// Handshake: imem_req_o/imem_addr_o are registered and held stable from the
// cycle req rises until the cycle imem_ack_i is seen high; ack is only legal
// while req is high and completes the transfer on that clock edge. Downstream,
// the head entry is consumed on an edge where ins_valid_o=1, stall_i=0 and
// redirect_i=0.
module if_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_4_o,
  output logic [31:0] ins_o,
  output logic        ins_valid_o,
  output logic        drain_o
);

  fetch_state_e       state_q;
  logic [31:0]        pc_q;
  logic [1:0]         cnt;
  logic [1:0]         cnt_n;
  logic               push;
  logic               pop;
  logic               issue;
  logic [2*INS_W-1:0] head;

  // Stale responses (DRAIN) and redirected ones are never written.
  assign push  = imem_ack_i & (state_q == RUN) & ~redirect_i;
  assign pop   = ins_valid_o & ~stall_i & ~redirect_i;
  assign cnt_n = cnt + {1'b0, push} - {1'b0, pop};

  // A new request may go out when the slot is free (or freeing now) and the
  // buffer will still have room for its response.
  assign issue = (state_q == RUN) & ~redirect_i &
                 (~imem_req_o | imem_ack_i) & (cnt_n <= 2'd1);

  fetch_skid_buf u_skid (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_i),
    .push  (push),
    .pop   (pop),
    .din   ({imem_addr_o + 32'd4, imem_rdata_i}),
    .head  (head),
    .count (cnt)
  );

  assign pc_4_o      = head[2*INS_W-1:INS_W];
  assign ins_o       = head[INS_W-1:0];
  assign ins_valid_o = (cnt != 2'd0) & (state_q == RUN);
  assign drain_o     = (state_q == DRAIN);

  // Fetch FSM: PC, request/address registers and redirect/drain handling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      imem_req_o  <= 1'b0;
      imem_addr_o <= 32'h0;
    end else begin
      case (state_q)
        RUN: begin
          if (redirect_i) begin
            pc_q <= word_align(redirect_pc_i);
            if (imem_req_o && !imem_ack_i) begin
              // Old request must still complete; hold req/addr and discard it.
              state_q <= DRAIN;
            end else begin
              imem_req_o <= 1'b0;
            end
          end else if (issue) begin
            imem_req_o  <= 1'b1;
            imem_addr_o <= pc_q;
            pc_q        <= pc_q + 32'd4;
          end else if (imem_ack_i) begin
            imem_req_o <= 1'b0;
          end
        end
        DRAIN: begin
          if (redirect_i) begin
            pc_q <= word_align(redirect_pc_i);
          end
          if (imem_ack_i) begin
            imem_req_o <= 1'b0;
            state_q    <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  // Protocol and occupancy invariants.
  a_no_ack_without_req: assert property (@(posedge clk) disable iff (rst)
    !(imem_ack_i && !imem_req_o));
  a_req_stable: assert property (@(posedge clk) disable iff (rst)
    (imem_req_o && !imem_ack_i) |=> (imem_req_o && $stable(imem_addr_o)));
  a_cnt_depth: assert property (@(posedge clk) disable iff (rst)
    int'(cnt) <= DEPTH);
  a_cnt_plus_req: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, cnt} + {2'b00, imem_req_o}) <= 3'd2);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a wait-state-programmable memory model.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] pc_4_o;
  logic [31:0] ins_o;
  logic        ins_valid_o;
  logic        drain_o;

  int n_run  = 0;
  int n_fail = 0;

  logic [1:0] wait_cfg;
  logic [1:0] wcnt;

  if_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .pc_4_o        (pc_4_o),
    .ins_o         (ins_o),
    .ins_valid_o   (ins_valid_o),
    .drain_o       (drain_o)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ack after wait_cfg extra cycles; cancels on reset.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign imem_ack_i   = imem_req_o & ~rst & (wcnt == wait_cfg);
  assign imem_rdata_i = mem_word(imem_addr_o);

  always @(posedge clk or posedge rst) begin
    if (rst)             wcnt <= 2'd0;
    else if (imem_ack_i) wcnt <= 2'd0;
    else if (imem_req_o) wcnt <= wcnt + 2'd1;
  end

  // Driver / check tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk1({tag, "_req"}, imem_req_o, 1'b0);
    chk({tag, "_addr"}, imem_addr_o, 32'h0);
    chk({tag, "_pc4"}, pc_4_o, 32'h0);
    chk({tag, "_ins"}, ins_o, 32'h0);
    chk1({tag, "_valid"}, ins_valid_o, 1'b0);
    chk1({tag, "_drain"}, drain_o, 1'b0);
  endtask

  initial begin
    rst           = 1'b1;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    wait_cfg      = 2'd0;

    // Reset state
    tick();
    tick();
    chk_zero("reset");
    rst = 1'b0;

    // Zero-wait streaming: first request one cycle after release
    tick();
    chk1("s1_req", imem_req_o, 1'b1);
    chk("s1_addr0", imem_addr_o, 32'h0);
    chk1("s1_valid0", ins_valid_o, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("s1_addr%0d", i), imem_addr_o, 32'(4 * i));
      chk($sformatf("s1_pc4_%0d", i), pc_4_o, 32'(4 * i));
      chk($sformatf("s1_ins%0d", i), ins_o, mem_word(32'(4 * i - 4)));
      chk1($sformatf("s1_valid%0d", i), ins_valid_o, 1'b1);
    end

    // Stall for 5 cycles: buffer fills, request drops, head holds entry 0x10
    stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1($sformatf("st_req%0d", i), imem_req_o, 1'b0);
      chk($sformatf("st_pc4_%0d", i), pc_4_o, 32'h14);
      chk1($sformatf("st_valid%0d", i), ins_valid_o, 1'b1);
    end
    stall_i = 1'b0;
    tick();
    chk1("rel_req", imem_req_o, 1'b1);
    chk("rel_addr", imem_addr_o, 32'h18);
    chk("rel_pc4_a", pc_4_o, 32'h18);
    tick();
    chk("rel_pc4_b", pc_4_o, 32'h1C);
    chk("rel_ins_b", ins_o, mem_word(32'h18));
    tick();
    chk("rel_pc4_c", pc_4_o, 32'h20);
    chk("rel_addr_c", imem_addr_o, 32'h20);

    // Three-cycle memory: each address held for 3 cycles, one word per 3 cycles
    wait_cfg = 2'd2;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk1($sformatf("w_valid_lo%0d", k), ins_valid_o, 1'b0);
      chk($sformatf("w_addr_a%0d", k), imem_addr_o, 32'(32 + 4 * k));
      tick();
      chk($sformatf("w_addr_b%0d", k), imem_addr_o, 32'(32 + 4 * k));
      tick();
      chk($sformatf("w_addr_c%0d", k), imem_addr_o, 32'(36 + 4 * k));
      chk($sformatf("w_pc4_%0d", k), pc_4_o, 32'(36 + 4 * k));
      chk($sformatf("w_ins_%0d", k), ins_o, mem_word(32'(32 + 4 * k)));
      chk1($sformatf("w_valid_hi%0d", k), ins_valid_o, 1'b1);
    end

    // Reset in the middle of a pending request
    rst = 1'b1;
    #1;
    chk_zero("midrst_a");
    tick();
    chk_zero("midrst_b");
    rst = 1'b0;
    tick();
    chk1("rr_req", imem_req_o, 1'b1);
    chk("rr_addr", imem_addr_o, 32'h0);
    tick();
    tick();
    chk("rr_addr_hold", imem_addr_o, 32'h0);
    tick();
    chk("rr_pc4_a", pc_4_o, 32'h4);
    chk("rr_addr_a", imem_addr_o, 32'h4);
    tick();
    tick();
    tick();
    chk("rr_pc4_b", pc_4_o, 32'h8);
    chk("rr_addr_b", imem_addr_o, 32'h8);
    tick();
    chk1("rr_valid_b", ins_valid_o, 1'b0);

    // Redirect while the fetch of 0x08 is waiting (low bits must be dropped)
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0103;
    tick();
    redirect_i = 1'b0;
    chk1("dr_drain", drain_o, 1'b1);
    chk1("dr_req", imem_req_o, 1'b1);
    chk("dr_addr", imem_addr_o, 32'h8);
    chk1("dr_valid", ins_valid_o, 1'b0);
    tick();
    chk1("dr_drain_end", drain_o, 1'b0);
    chk1("dr_req_end", imem_req_o, 1'b0);
    chk1("dr_valid_end", ins_valid_o, 1'b0);
    tick();
    chk("dr_new_addr", imem_addr_o, 32'h100);
    chk1("dr_new_req", imem_req_o, 1'b1);
    tick();
    tick();
    tick();
    chk("dr_pc4", pc_4_o, 32'h104);
    chk("dr_ins", ins_o, mem_word(32'h100));
    chk1("dr_valid_new", ins_valid_o, 1'b1);

    // Redirect coinciding with ack and stall
    wait_cfg      = 2'd0;
    stall_i       = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h200;
    tick();
    stall_i    = 1'b0;
    redirect_i = 1'b0;
    chk1("rs_valid", ins_valid_o, 1'b0);
    chk1("rs_req", imem_req_o, 1'b0);
    chk1("rs_drain", drain_o, 1'b0);
    tick();
    chk("rs_addr", imem_addr_o, 32'h200);
    tick();
    chk("rs_pc4", pc_4_o, 32'h204);
    chk("rs_ins", ins_o, mem_word(32'h200));

    // PC wrap at the top of the address space
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFF8;
    tick();
    redirect_i = 1'b0;
    chk1("wr_req", imem_req_o, 1'b0);
    tick();
    chk("wr_addr_a", imem_addr_o, 32'hFFFF_FFF8);
    tick();
    chk("wr_pc4_b", pc_4_o, 32'hFFFF_FFFC);
    chk("wr_addr_b", imem_addr_o, 32'hFFFF_FFFC);
    tick();
    chk("wr_pc4_c", pc_4_o, 32'h0);
    chk("wr_addr_c", imem_addr_o, 32'h0);
    chk("wr_ins_c", ins_o, mem_word(32'hFFFF_FFFC));
    tick();
    chk("wr_pc4_d", pc_4_o, 32'h4);
    chk("wr_addr_d", imem_addr_o, 32'h4);

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the PC and issues requests to instruction memory over a req/ack handshake that tolerates wait states. Returned words go into a 2-entry skid buffer, which presents {pc+4, instruction, valid} to IF/ID. It honours hazard stalls, and it honours branch/jump redirects from later stages even when a memory request is still in flight.

Parameters:
RESET_PC, 32'h0000_0000, address of the first fetch after reset
DEPTH, 2, skid-buffer entries (fixed at 2; parameter exists for assertions only)

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
stall_i  input  1  hazard unit holds IF/ID (IF/ID we low); head entry must not be consumed
redirect_i  input  1  taken branch/jump; flush everything and refetch
redirect_pc_i  input  32  target address for redirect_i
imem_req_o  output  1  fetch request (registered)
imem_addr_o  output  32  fetch address (registered, word aligned)
imem_ack_i  input  1  memory returns data this cycle; may assert in the same cycle imem_req_o first rises
imem_rdata_i  input  32  instruction word, valid when imem_ack_i
pc_4_o  output  32  head entry's fetch address + 4
ins_o  output  32  head entry instruction
ins_valid_o  output  1  head entry valid; top level drives IF/ID zero = redirect_i | ~ins_valid_o
drain_o  output  1  high while a stale in-flight response is being discarded

Behaviour:
- Reset (async): pc_q=RESET_PC, imem_req_o=0, imem_addr_o=0, buffer count=0, ins_valid_o=0, pc_4_o=0, ins_o=0, state=RUN, drain_o=0.
- Handshake:
  - Once imem_req_o=1, it and imem_addr_o stay stable until the cycle imem_ack_i=1.
  - At most one request is outstanding.
  - imem_ack_i while imem_req_o=0 is a protocol error (assertion).
- Consumption: pop = ins_valid_o & ~stall_i & ~redirect_i. Head leaves on that clock edge.
- Buffer next count: cnt_n = cnt + (ack & state==RUN & ~redirect_i) - pop. The 2-bit counter never exceeds 2.
- Issue rule at each edge, evaluated in state RUN with no redirect:
  - If imem_req_o=0, or imem_req_o=1 with ack this cycle, and cnt_n<=1: set imem_req_o=1, imem_addr_o=pc_q, pc_q<=pc_q+4.
  - Otherwise, if ack this cycle, imem_req_o<=0.
  - Result: zero-wait memory with no stall sustains 1 instruction/cycle. First request is visible 1 cycle after rst falls.
- Write on ack: the stored entry is {imem_addr_o+4, imem_rdata_i}.
- State RUN:
  - redirect_i and imem_req_o=1 and ~ack: flush buffer (cnt=0), pc_q<=redirect_pc_i, go DRAIN. Req/addr held for the old address.
  - redirect_i with no outstanding request, or with ack this cycle: flush buffer, discard ack data, imem_req_o<=0, pc_q<=redirect_pc_i, stay RUN. The new target is issued on the next edge.
- State DRAIN (drain_o=1): no buffer writes; ins_valid_o=0.
  - On ack: imem_req_o<=0, go RUN.
  - A further redirect_i in DRAIN only overwrites pc_q (latest target wins).
- Simultaneous events:
  - redirect beats stall and pop.
  - Stall with full buffer and ack pending is impossible by the issue rule (assert cnt+req<=2).
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0. redirect_pc_i[1:0] is forced to 0.
- Reset mid-transfer: request dropped immediately. The memory model must cancel on rst.

Decomposition:
- Shared package cpu_pkg: RESET_PC default, INS_W=32, NOP encoding 32'h0000_0000, fetch FSM state enum {RUN, DRAIN}.
- One sub-module fetch_skid_buf: 2-entry FIFO of 64-bit {pc_4, ins} with push, pop, flush and count. Flush has priority over push and pop.

Test Plan:
- Reset release, zero-wait memory, no stall -> addresses 0,4,8,... on consecutive cycles; pc_4_o=4,8,12 one per cycle; ins_valid_o=1 from cycle 2.
- Memory with 3-cycle wait states -> imem_addr_o stable across each wait; one instruction per 3 cycles; no duplicates or drops.
- stall_i held 5 cycles during streaming -> buffer fills to 2, imem_req_o drops; head stays stable; resumes in order with no loss after release.
- redirect_i to 32'h0000_0100 while a 3-cycle-wait fetch of 0x08 is pending -> drain_o=1 until ack; 0x08 data discarded; next request is 0x100 and the next pc_4_o is 0x104.
- redirect_i in the same cycle as ack and stall -> buffer empty next cycle; ins_valid_o=0; next request is the target.
- Assert rst mid-request, then release -> all outputs zero during reset; first request afterwards is at RESET_PC.
